// File: rtl/sim_mod_err_pkg.sv
// Shared types and constants for the square-wave modulation generator and
// its synchronous error demodulator.
package sim_mod_err_pkg;

    localparam int AVG_SEL_MAX  = 10;
    localparam int ACC_W        = 48;
    localparam int MIN_FREQ_CNT = 2;
    localparam int DATA_W       = 32;

    typedef logic signed [DATA_W-1:0] data_t;

    typedef enum logic {
        HALF_L = 1'b0,
        HALF_H = 1'b1
    } half_e;

    localparam logic signed [33:0] SAT_MAX = 34'sh0_7FFF_FFFF;
    localparam logic signed [33:0] SAT_MIN = 34'sh3_8000_0000;

    // Clamp a 34-bit signed error term into the 32-bit output range.
    function automatic data_t sat32(input logic signed [33:0] v);
        data_t r;
        if (v > SAT_MAX) begin
            r = 32'sh7FFF_FFFF;
        end else if (v < SAT_MIN) begin
            r = 32'sh8000_0000;
        end else begin
            r = v[31:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/sim_mod_err_avg.sv
// Windowed accumulate-and-shift averager: sums ADC samples inside the
// sampling window of each half-period and latches the mean per half.
module sim_mod_err_avg
    import sim_mod_err_pkg::*;
#(
    parameter int ADC_BIT = 14
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [31:0]               i_cnt,
    input  logic [31:0]               i_fc,
    input  logic [31:0]               i_wait_cnt,
    input  logic [3:0]                i_avg_sel,
    input  logic signed [ADC_BIT-1:0] i_adc_data,
    input  logic                      i_half_end,
    input  logic                      i_status,
    output data_t                     o_avg_H,
    output data_t                     o_avg_L
);

    logic [32:0]              w_n;
    logic [32:0]              w_win_hi;
    logic                     w_in_win;
    logic signed [ACC_W-1:0]  w_adc_ext;
    logic signed [ACC_W-1:0]  w_acc_sum;
    data_t                    w_avg;

    logic signed [ACC_W-1:0]  r_acc;
    data_t                    r_avg [2];

    // Window upper bound kept at 33 bits so a large wait count cannot wrap.
    assign w_n       = 33'd1 << i_avg_sel;
    assign w_win_hi  = {1'b0, i_wait_cnt} + w_n;
    assign w_in_win  = (i_cnt >= i_wait_cnt) && ({1'b0, i_cnt} < w_win_hi) && (i_cnt < i_fc);

    assign w_adc_ext = {{(ACC_W-ADC_BIT){i_adc_data[ADC_BIT-1]}}, i_adc_data};
    assign w_acc_sum = r_acc + (w_in_win ? w_adc_ext : '0);

    // A truncated window still divides by 2^avg_sel, as downstream expects.
    assign w_avg     = 32'(w_acc_sum >>> i_avg_sel);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_half_end) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_acc_sum;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_avg
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_avg[gi] <= '0;
                end else if (i_half_end && (i_status == 1'(gi))) begin
                    r_avg[gi] <= w_avg;
                end
            end
        end
    endgenerate

    assign o_avg_L = r_avg[0];
    assign o_avg_H = r_avg[1];

endmodule

// File: rtl/sim_mod_err_gen.sv
// Square-wave bias modulation generator with synchronous H-L error
// demodulation; one error update and step trigger per full period.
module sim_mod_err_gen
    import sim_mod_err_pkg::*;
#(
    parameter int ADC_BIT = 14
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [31:0]               i_freq_cnt,
    input  logic signed [31:0]        i_amp_H,
    input  logic signed [31:0]        i_amp_L,
    input  logic                      i_polarity,
    input  logic [31:0]               i_wait_cnt,
    input  logic signed [31:0]        i_err_offset,
    input  logic signed [ADC_BIT-1:0] i_adc_data,
    input  logic [31:0]               i_avg_sel,
    output logic signed [31:0]        o_mod_out,
    output logic                      o_status,
    output logic                      o_stepTrig,
    output logic signed [31:0]        o_err
);

    logic [31:0]        w_fc;
    logic [3:0]         w_avg_sel;
    logic               w_half_end;
    logic [31:0]        w_cnt_next;
    half_e              w_half_next;
    data_t              w_avg_H;
    data_t              w_avg_L;
    logic signed [33:0] w_avg_H_ext;
    logic signed [33:0] w_avg_L_ext;
    logic signed [33:0] w_off_ext;
    logic signed [33:0] w_diff;
    logic signed [33:0] w_err_raw;

    logic [31:0]        r_cnt;
    half_e              r_half;
    data_t              r_mod;
    logic               r_err_pend;
    logic               r_step;
    data_t              r_err;

    assign w_fc      = (i_freq_cnt < 32'(MIN_FREQ_CNT)) ? 32'(MIN_FREQ_CNT) : i_freq_cnt;
    assign w_avg_sel = (i_avg_sel > 32'(AVG_SEL_MAX)) ? 4'(AVG_SEL_MAX) : i_avg_sel[3:0];
    assign w_half_end = (r_cnt >= (w_fc - 32'd1));

    always_comb begin
        w_cnt_next  = r_cnt + 32'd1;
        w_half_next = r_half;
        if (w_half_end) begin
            w_cnt_next  = '0;
            w_half_next = (r_half == HALF_H) ? HALF_L : HALF_H;
        end
    end

    sim_mod_err_avg #(
        .ADC_BIT (ADC_BIT)
    ) u_avg (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_cnt      (r_cnt),
        .i_fc       (w_fc),
        .i_wait_cnt (i_wait_cnt),
        .i_avg_sel  (w_avg_sel),
        .i_adc_data (i_adc_data),
        .i_half_end (w_half_end),
        .i_status   (r_half == HALF_H),
        .o_avg_H    (w_avg_H),
        .o_avg_L    (w_avg_L)
    );

    // Difference is formed one edge after the H half closes so both means are settled.
    assign w_avg_H_ext = {{2{w_avg_H[31]}}, w_avg_H};
    assign w_avg_L_ext = {{2{w_avg_L[31]}}, w_avg_L};
    assign w_off_ext   = {{2{i_err_offset[31]}}, i_err_offset};
    assign w_diff      = i_polarity ? (w_avg_L_ext - w_avg_H_ext) : (w_avg_H_ext - w_avg_L_ext);
    assign w_err_raw   = w_diff - w_off_ext;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt      <= '0;
            r_half     <= HALF_L;
            r_mod      <= '0;
            r_err_pend <= 1'b0;
            r_step     <= 1'b0;
            r_err      <= '0;
        end else begin
            r_cnt      <= w_cnt_next;
            r_half     <= w_half_next;
            r_mod      <= (w_half_next == HALF_H) ? i_amp_H : i_amp_L;
            r_err_pend <= w_half_end && (r_half == HALF_H);
            r_step     <= r_err_pend;
            if (r_err_pend) begin
                r_err <= sat32(w_err_raw);
            end
        end
    end

    assign o_mod_out  = r_mod;
    assign o_status   = (r_half == HALF_H);
    assign o_stepTrig = r_step;
    assign o_err      = r_err;

endmodule

// File: tb/tb_sim_mod_err_gen.sv
// Self-checking bench for sim_mod_err_gen: directed scenarios plus random
// configurations, compared every cycle against a behavioural period model.
module tb_sim_mod_err_gen;

    localparam int ADC_BIT = 14;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic [31:0]               freq;
    logic signed [31:0]        amp_h;
    logic signed [31:0]        amp_l;
    logic                      pol;
    logic [31:0]               wait_c;
    logic signed [31:0]        offset;
    logic signed [ADC_BIT-1:0] adc;
    logic [31:0]               avg_sel;
    logic signed [31:0]        mod_out;
    logic                      status;
    logic                      step_trig;
    logic signed [31:0]        err;

    always #5 clk = ~clk;

    sim_mod_err_gen #(.ADC_BIT(ADC_BIT)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_freq_cnt   (freq),
        .i_amp_H      (amp_h),
        .i_amp_L      (amp_l),
        .i_polarity   (pol),
        .i_wait_cnt   (wait_c),
        .i_err_offset (offset),
        .i_adc_data   (adc),
        .i_avg_sel    (avg_sel),
        .o_mod_out    (mod_out),
        .o_status     (status),
        .o_stepTrig   (step_trig),
        .o_err        (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: position within the half, collected window sum,
    // per-half means and the error emitted one edge after each H half.
    longint m_pos, m_sum, m_avg_h, m_avg_l, m_err, m_mod;
    bit     m_high, m_trig, m_pend;

    always @(posedge clk or negedge rst_n) begin
        longint fc, n, sel, d, q, e;
        if (!rst_n) begin
            m_pos = 0; m_sum = 0; m_avg_h = 0; m_avg_l = 0;
            m_err = 0; m_mod = 0; m_high = 0; m_trig = 0; m_pend = 0;
        end else begin
            fc  = (freq < 2) ? 2 : longint'(freq);
            sel = (avg_sel > 10) ? 10 : longint'(avg_sel);
            n   = longint'(1) << sel;
            m_trig = m_pend;
            if (m_pend) begin
                d = pol ? (m_avg_l - m_avg_h) : (m_avg_h - m_avg_l);
                e = d - longint'(offset);
                if (e > 64'sd2147483647) e = 64'sd2147483647;
                if (e < -64'sd2147483648) e = -64'sd2147483648;
                m_err = e;
            end
            if (m_pos >= longint'(wait_c) && m_pos < longint'(wait_c) + n && m_pos < fc)
                m_sum += longint'(adc);
            if (m_pos >= fc - 1) begin
                q = m_sum / n;
                if ((m_sum % n) != 0 && m_sum < 0) q = q - 1;
                q = longint'(int'(q));
                if (m_high) m_avg_h = q; else m_avg_l = q;
                m_sum  = 0;
                m_pend = m_high;
                m_high = !m_high;
                m_pos  = 0;
            end else begin
                m_pos  = m_pos + 1;
                m_pend = 0;
            end
            m_mod = m_high ? longint'(amp_h) : longint'(amp_l);
        end
    end

    // ADC stimulus modes
    localparam int A_CONST = 0, A_FOLLOW = 1, A_RAMP = 2, A_RAND = 3, A_SAT = 4;
    int adc_mode = A_CONST;
    int ramp_div = 0;

    task automatic step();
        @(negedge clk);
        if (rst_n) begin
            check_val("status", status, longint'(m_high));
            check_val("mod_out", mod_out, m_mod);
            check_val("step_trig", step_trig, longint'(m_trig));
            check_val("err", err, m_err);
        end
        case (adc_mode)
            A_FOLLOW: adc = status ? 14'sd200 : 14'sd100;
            A_RAMP: begin
                ramp_div++;
                if (ramp_div == 10) begin
                    ramp_div = 0;
                    adc = adc + 14'sd1;
                end
            end
            A_RAND:  adc = ADC_BIT'($urandom);
            A_SAT:   adc = status ? 14'sd8191 : -14'sd8192;
            default: ;
        endcase
    endtask

    task automatic wait_trig(input string tag, input int max, output int cyc);
        cyc = 0;
        do begin
            step();
            cyc++;
        end while (!step_trig && cyc < max);
        if (!step_trig) check_val({tag, "_timeout"}, step_trig, 1);
    endtask

    task automatic setup_common();
        freq = 50; amp_h = 1000; amp_l = -1000; wait_c = 10;
        avg_sel = 4; offset = 50; pol = 0;
    endtask

    initial begin
        int cyc;
        setup_common();
        adc = 0;
        rst_n = 0;
        repeat (3) step();
        check_val("rst_mod_out", mod_out, 0);
        check_val("rst_status", status, 0);
        check_val("rst_step", step_trig, 0);
        check_val("rst_err", err, 0);

        // Constant ADC: equal means, error is just -offset
        adc_mode = A_CONST;
        adc = 100;
        rst_n = 1;
        step();
        check_val("first_half_L", mod_out, -1000);
        wait_trig("c_trig0", 300, cyc);
        check_val("c_first_lat", cyc + 1, 101);
        check_val("c_err0", err, -50);
        for (int k = 0; k < 3; k++) begin
            wait_trig("c_trig", 300, cyc);
            check_val("c_period", cyc, 100);
            check_val("c_err", err, -50);
        end
        $display("const adc: err=%0d", err);

        // ADC follows the half; then flip polarity
        adc_mode = A_FOLLOW;
        for (int k = 0; k < 2; k++) wait_trig("f_trig", 300, cyc);
        check_val("f_err_pos", err, 50);
        $display("follow pol0: err=%0d", err);
        pol = 1;
        wait_trig("f_trig_p1", 300, cyc);
        check_val("f_err_neg", err, -150);
        $display("follow pol1: err=%0d", err);

        // Slow ramp against the model
        pol = 0;
        adc_mode = A_RAMP;
        adc = 0;
        for (int k = 0; k < 5; k++) begin
            wait_trig("r_trig", 300, cyc);
            check_val("r_err", err, m_err);
            $display("ramp trig %0d: err=%0d", k, err);
        end

        // Minimum half period, single-sample averaging
        freq = 2; wait_c = 0; avg_sel = 0; offset = 7;
        adc_mode = A_RAND;
        wait_trig("m_trig0", 20, cyc);
        for (int k = 0; k < 6; k++) begin
            wait_trig("m_trig", 20, cyc);
            check_val("m_period", cyc, 4);
            check_val("m_err", err, m_err);
        end
        $display("freq=2: err=%0d", err);

        // Reset pulse in the middle of an H half
        setup_common();
        adc_mode = A_CONST;
        adc = 100;
        cyc = 0;
        do begin step(); cyc++; end while (!status && cyc < 200);
        check_val("to_h_half", status, 1);
        repeat (20) step();
        #2 rst_n = 0;
        #1;
        check_val("mid_rst_mod", mod_out, 0);
        check_val("mid_rst_status", status, 0);
        check_val("mid_rst_step", step_trig, 0);
        check_val("mid_rst_err", err, 0);
        repeat (3) step();
        rst_n = 1;
        step();
        check_val("restart_L", status, 0);
        check_val("restart_mod", mod_out, -1000);
        wait_trig("rst_trig", 300, cyc);
        check_val("rst_first_lat", cyc + 1, 101);
        $display("reset restart: first trig after %0d clks", cyc + 1);

        // Saturation toward +max
        offset = 32'sh8000_0000;
        adc_mode = A_SAT;
        for (int k = 0; k < 2; k++) wait_trig("s_trig", 300, cyc);
        check_val("sat_err", err, 64'sd2147483647);
        $display("saturation: err=%0d", err);

        // Random configurations, live changes, model checked each cycle
        adc_mode = A_RAND;
        for (int r = 0; r < 12; r++) begin
            freq    = $urandom_range(0, 40);
            wait_c  = $urandom_range(0, 20);
            avg_sel = $urandom_range(0, 12);
            pol     = 1'($urandom);
            offset  = $signed($urandom_range(0, 4000)) - 2000;
            amp_h   = $urandom;
            amp_l   = $urandom;
            repeat (250) step();
            $display("random cfg %0d: freq=%0d wait=%0d sel=%0d err=%0d", r, freq, wait_c, avg_sel, err);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
